// File: rtl/incdec_addr_latch_if.sv
// Bus between the register file (master) and the address latch/incrementer (slave).
// Optional macro INCDEC_KFLAG_EN adds the kflag wrap indicator to the bus.
interface incdec_addr_latch_if #(
  parameter int AW = 16
) ();
  logic [AW-1:0] addr_in;
  logic          ld;
  logic          start;
  logic [1:0]    op;
  logic [AW-1:0] addr_out;
  logic          busy;
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_data;
  logic          done;
`ifdef INCDEC_KFLAG_EN
  logic          kflag;
`endif

  modport master (
    output addr_in, ld, start, op, wb_ready,
    input  addr_out, busy, wb_valid, wb_data, done
`ifdef INCDEC_KFLAG_EN
    , input kflag
`endif
  );

  modport slave (
    input  addr_in, ld, start, op, wb_ready,
    output addr_out, busy, wb_valid, wb_data, done
`ifdef INCDEC_KFLAG_EN
    , output kflag
`endif
  );
endinterface

// File: rtl/incdec_addr_latch.sv
// 16-bit address latch with +/-1 unit and valid/ready write-back to the register file.
// Optional macro INCDEC_KFLAG_EN: kflag output flags a wrapping inc/dec.
//
// state   | meaning
// IDLE    | nothing latched since reset or last write-back
// LATCHED | pair held on addr_out, waiting for ld or start
// CALC    | one cycle computing latch +/- 1
// WB      | wb_valid high, waiting for wb_ready
module incdec_addr_latch #(
  parameter int            AW         = 16,
  parameter logic [AW-1:0] RESET_ADDR = '0
) (
  input logic                 clk,
  input logic                 rst,
  incdec_addr_latch_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCHED = 2'd1,
    CALC    = 2'd2,
    WB      = 2'd3
  } state_t;

  localparam logic [1:0] OP_INC = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;

  state_t        state_q, state_d;
  logic [AW-1:0] latch_q, latch_d;
  logic [AW-1:0] wb_data_q, wb_data_d;
  logic [1:0]    op_q, op_d;
  logic          done_q, done_d;
  logic [AW-1:0] calc_res;
  logic          calc_wrap;

  always_comb begin
    calc_res  = latch_q;
    calc_wrap = 1'b0;
    if (op_q == OP_INC) begin
      calc_res  = latch_q + {{(AW-1){1'b0}}, 1'b1};
      calc_wrap = &latch_q;
    end else if (op_q == OP_DEC) begin
      calc_res  = latch_q - {{(AW-1){1'b0}}, 1'b1};
      calc_wrap = ~|latch_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    latch_d   = latch_q;
    wb_data_d = wb_data_q;
    op_d      = op_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ld) begin
          latch_d = bus.addr_in;
          state_d = LATCHED;
        end
      end
      LATCHED: begin
        // ld wins over a same-cycle start
        if (bus.ld) begin
          latch_d = bus.addr_in;
        end else if (bus.start) begin
          if (bus.op == OP_INC || bus.op == OP_DEC) begin
            op_d    = bus.op;
            state_d = CALC;
          end else begin
            wb_data_d = latch_q;
            state_d   = WB;
          end
        end
      end
      CALC: begin
        wb_data_d = calc_res;
        state_d   = WB;
      end
      WB: begin
        if (bus.wb_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      latch_q   <= RESET_ADDR;
      wb_data_q <= RESET_ADDR;
      op_q      <= 2'b00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      latch_q   <= latch_d;
      wb_data_q <= wb_data_d;
      op_q      <= op_d;
      done_q    <= done_d;
    end
  end

`ifdef INCDEC_KFLAG_EN
  logic kflag_q, kflag_d;

  always_comb begin
    kflag_d = kflag_q;
    if (state_q == CALC) kflag_d = calc_wrap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) kflag_q <= 1'b0;
    else      kflag_q <= kflag_d;
  end

  assign bus.kflag = kflag_q;
`else
  logic unused_wrap;
  assign unused_wrap = calc_wrap;
`endif

  // wb_valid/busy decode straight from state so an async reset drops them at once
  assign bus.addr_out = latch_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_valid = (state_q == WB);
  assign bus.busy     = (state_q == CALC) || (state_q == WB);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_incdec_addr_latch.sv
// Directed self-checking bench for incdec_addr_latch (define INCDEC_KFLAG_EN to also check kflag).
module tb_incdec_addr_latch;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  incdec_addr_latch_if #(.AW(16)) bus ();

  incdec_addr_latch #(.AW(16), .RESET_ADDR(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [15:0] a, input logic [1:0] o, input logic [15:0] exp_wb,
                       input int exp_lat, input logic exp_k);
    int n;
    bus.addr_in = a;
    bus.ld      = 1'b1;
    tick();
    bus.ld = 1'b0;
    chk("ld_addr", 32'(bus.addr_out), 32'(a));
    bus.start    = 1'b1;
    bus.op       = o;
    bus.wb_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    n = 1;
    while (!bus.wb_valid && n < 8) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("wb_data", 32'(bus.wb_data), 32'(exp_wb));
    chk("addr_hold", 32'(bus.addr_out), 32'(a));
    chk("busy_wb", 32'(bus.busy), 32'd1);
`ifdef INCDEC_KFLAG_EN
    chk("kflag", 32'(bus.kflag), 32'(exp_k));
`else
    if (exp_k === 1'bx) chk("kflag_arg", 32'(exp_k), 32'd0);
`endif
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    chk("done", 32'(bus.done), 32'd1);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("wb_valid_off", 32'(bus.wb_valid), 32'd0);
    tick();
    chk("done_pulse", 32'(bus.done), 32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b0;
    bus.addr_in  = '0;
    bus.ld       = 1'b0;
    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.wb_ready = 1'b0;
    tick();
    tick();
    chk("rst_addr", 32'(bus.addr_out), 32'h0);
    chk("rst_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
`ifdef INCDEC_KFLAG_EN
    chk("rst_kflag", 32'(bus.kflag), 32'd0);
`endif
    rst = 1'b1;
    tick();

    // start in IDLE must not launch anything
    bus.start = 1'b1;
    bus.op    = 2'b01;
    tick();
    tick();
    bus.start = 1'b0;
    chk("idle_start_busy", 32'(bus.busy), 32'd0);
    chk("idle_start_valid", 32'(bus.wb_valid), 32'd0);
    chk("idle_start_addr", 32'(bus.addr_out), 32'h0);

    // increment with cycle-by-cycle view
    bus.addr_in = 16'h1234;
    bus.ld      = 1'b1;
    tick();
    bus.ld = 1'b0;
    chk("inc_ld", 32'(bus.addr_out), 32'h1234);
    bus.start    = 1'b1;
    bus.op       = 2'b01;
    bus.wb_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("inc_calc_busy", 32'(bus.busy), 32'd1);
    chk("inc_calc_valid", 32'(bus.wb_valid), 32'd0);
    tick();
    chk("inc_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("inc_wb_data", 32'(bus.wb_data), 32'h1235);
    chk("inc_wb_done", 32'(bus.done), 32'd0);
    tick();
    bus.wb_ready = 1'b0;
    chk("inc_done", 32'(bus.done), 32'd1);
    chk("inc_idle_busy", 32'(bus.busy), 32'd0);
    chk("inc_addr", 32'(bus.addr_out), 32'h1234);
    tick();
    chk("inc_done_pulse", 32'(bus.done), 32'd0);

    // wrap cases and kflag handling
    do_op(16'h0000, 2'b10, 16'hFFFF, 2, 1'b1);
    do_op(16'h0042, 2'b00, 16'h0042, 1, 1'b1);
    do_op(16'hFFFF, 2'b01, 16'h0000, 2, 1'b1);
    do_op(16'h00AA, 2'b01, 16'h00AB, 2, 1'b0);
    do_op(16'h8000, 2'b10, 16'h7FFF, 2, 1'b0);

    // backpressure: ld/start ignored while in WB
    bus.addr_in = 16'h1234;
    bus.ld      = 1'b1;
    tick();
    bus.ld        = 1'b0;
    bus.start     = 1'b1;
    bus.op        = 2'b01;
    bus.wb_ready  = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.addr_in = 16'h5555;
      bus.ld      = 1'b1;
      bus.start   = 1'b1;
      bus.op      = 2'b10;
      chk("bp_valid", 32'(bus.wb_valid), 32'd1);
      chk("bp_data", 32'(bus.wb_data), 32'h1235);
      chk("bp_busy", 32'(bus.busy), 32'd1);
      chk("bp_addr", 32'(bus.addr_out), 32'h1234);
      tick();
    end
    bus.ld       = 1'b0;
    bus.start    = 1'b0;
    bus.wb_ready = 1'b1;
    chk("bp_data_end", 32'(bus.wb_data), 32'h1235);
    tick();
    bus.wb_ready = 1'b0;
    chk("bp_done", 32'(bus.done), 32'd1);
    chk("bp_idle", 32'(bus.busy), 32'd0);
    chk("bp_addr_end", 32'(bus.addr_out), 32'h1234);
    tick();

    // ld beats start; then pass-through with reserved op
    bus.addr_in = 16'h0101;
    bus.ld      = 1'b1;
    tick();
    bus.addr_in = 16'hAA11;
    bus.start   = 1'b1;
    bus.op      = 2'b01;
    tick();
    bus.ld    = 1'b0;
    bus.start = 1'b0;
    chk("prio_addr", 32'(bus.addr_out), 32'hAA11);
    chk("prio_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("prio_still_idle", 32'(bus.busy), 32'd0);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    tick();
    bus.start = 1'b0;
    chk("hold11_valid", 32'(bus.wb_valid), 32'd1);
    chk("hold11_data", 32'(bus.wb_data), 32'hAA11);
`ifdef INCDEC_KFLAG_EN
    chk("hold11_kflag", 32'(bus.kflag), 32'd0);
`endif
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    chk("hold11_done", 32'(bus.done), 32'd1);
    tick();

    // async reset while waiting in WB
    bus.addr_in = 16'h0042;
    bus.ld      = 1'b1;
    tick();
    bus.ld    = 1'b0;
    bus.start = 1'b1;
    bus.op    = 2'b01;
    tick();
    bus.start = 1'b0;
    tick();
    chk("mid_valid_pre", 32'(bus.wb_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_valid_drop", 32'(bus.wb_valid), 32'd0);
    chk("mid_addr", 32'(bus.addr_out), 32'h0);
    chk("mid_busy", 32'(bus.busy), 32'd0);
    bus.wb_ready = 1'b1;
    tick();
    rst = 1'b1;
    chk("mid_no_done", 32'(bus.done), 32'd0);
    tick();
    chk("mid_no_done2", 32'(bus.done), 32'd0);
    chk("mid_valid_off", 32'(bus.wb_valid), 32'd0);
    bus.wb_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
